colour_sensor_ctrl: RTL and testbench

- Parametrised successor to the single-purpose TCS3200-style colour sensor loop.
- Sequences the sensor filter selects (s2/s3) through red, blue, clear and green, with a settle blank after each switch.
- Counts synchronised rising edges of the sensor output in a fixed window and classifies the dominant colour with margin and clear-level checks.
- Debounces the classification over consecutive rounds, then drives the colour code and the R/G/B indicator LEDs.

---
 rtl/colour_sensor_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_colour_sensor_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/colour_sensor_ctrl.sv
// -----------------------------------------------------------------------------
// colour_sensor_ctrl
//
// Drives a TCS3200-style colour sensor. The filter selects (s2/s3) step through
// red, blue, clear and green. Each channel gets a settle blank, then a
// measurement window in which synchronised rising edges of the sensor output
// are counted. After green, the four counts are published and the dominant
// colour is classified. A classification must repeat on CONFIRM_ROUNDS
// consecutive rounds before colour_code and the LEDs change.
//
// Parameters:
//   WINDOW_CYCLES  clk cycles per measurement window
//   SETTLE_CYCLES  blank cycles after each filter change (0 allowed)
//   CNT_W          edge counter width; counters saturate at 2^CNT_W-1
//   CLEAR_MIN      minimum clear count for a valid classification
//   MARGIN         lead the winning channel needs over the other two
//   CONFIRM_ROUNDS identical classifications needed before outputs update
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   enable        runs the measurement sequence while high
//   colour_freq   asynchronous sensor frequency output
//   s2, s3        filter selects: red 00, blue 01, clear 10, green 11
//   red_cnt ..    last completed counts for each channel
//   clear_cnt
//   result_valid  one-cycle pulse when the four counts update
//   colour_code   confirmed colour: 0 none, 1 red, 2 green, 3 blue
//   red_led ..    one-hot decode of colour_code
//   blue_led
//
// Build option:
//   COLSEN_AVG_EN  when defined, each published count is the mean of the
//                  previous published count and the new one; the first round
//                  after reset or after a restart from idle is unaveraged.
// -----------------------------------------------------------------------------
module colour_sensor_ctrl #(
  parameter int WINDOW_CYCLES  = 1000000,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int CNT_W          = 16,
  parameter int CLEAR_MIN      = 200,
  parameter int MARGIN         = 50,
  parameter int CONFIRM_ROUNDS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             colour_freq,
  output logic             s2,
  output logic             s3,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic             result_valid,
  output logic [1:0]       colour_code,
  output logic             red_led,
  output logic             green_led,
  output logic             blue_led
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEAS, S_CLASSIFY} state_t;

  // Encoding equals the {s2,s3} filter select, and +1 gives the next channel.
  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_BLUE  = 2'd1,
    CH_CLEAR = 2'd2,
    CH_GREEN = 2'd3
  } chan_t;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_RED   = 2'd1;
  localparam logic [1:0] C_GREEN = 2'd2;
  localparam logic [1:0] C_BLUE  = 2'd3;

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  localparam int STRK_W = $clog2(CONFIRM_ROUNDS + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(CONFIRM_ROUNDS);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   MARGIN_W = (CNT_W+1)'(MARGIN);

  // With no settle blank, a channel goes straight into its measurement window.
  localparam state_t S_ENTRY = (SETTLE_CYCLES == 0) ? S_MEAS : S_SETTLE;

  state_t           state, state_nxt;
  chan_t            ch, ch_nxt;
  logic [TMR_W-1:0] tmr;

  logic             sync1, sync2, prev;
  logic             edge_det;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             meas_done;

  logic [CNT_W-1:0] stage_r, stage_g, stage_b, stage_c;
  logic [CNT_W-1:0] new_r, new_g, new_b, new_c;

  logic [1:0]        cls, cand, code_nxt;
  logic [STRK_W-1:0] streak, streak_nxt;

`ifdef COLSEN_AVG_EN
  logic have_prev;

  function automatic logic [CNT_W-1:0] avg2(input logic [CNT_W-1:0] a,
                                            input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W:1];
  endfunction
`endif

  // True when x leads both y and z by at least MARGIN; one extra bit keeps
  // y+MARGIN from wrapping.
  function automatic logic beats(input logic [CNT_W-1:0] x,
                                 input logic [CNT_W-1:0] y,
                                 input logic [CNT_W-1:0] z);
    logic [CNT_W:0] xw, yw, zw;
    xw = {1'b0, x};
    yw = {1'b0, y} + MARGIN_W;
    zw = {1'b0, z} + MARGIN_W;
    return (xw >= yw) && (xw >= zw);
  endfunction

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the reset branch lives inside the clocked block, so reset only
    // takes effect on a clock edge; every register here uses non-blocking
    // assignment so all flops see pre-edge values.
    if (rst) begin
      state <= S_IDLE;
      ch    <= CH_RED;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch
    // is inferred.
    state_nxt = state;
    ch_nxt    = ch;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_ENTRY;
          ch_nxt    = CH_RED;
        end
      end
      S_SETTLE: begin
        if (!enable)                 state_nxt = S_IDLE;
        else if (tmr == SETTLE_LAST) state_nxt = S_MEAS;
      end
      S_MEAS: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (tmr == WIN_LAST) begin
          if (ch == CH_GREEN) begin
            state_nxt = S_CLASSIFY;
          end else begin
            state_nxt = S_ENTRY;
            ch_nxt    = chan_t'(ch + 2'd1);
          end
        end
      end
      S_CLASSIFY: begin
        if (enable) begin
          state_nxt = S_ENTRY;
          ch_nxt    = CH_RED;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Cycle counter within the current state/channel; restarts on any change.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE || state_nxt != state || ch_nxt != ch) tmr <= '0;
    else                                                              tmr <= tmr + TMR_W'(1);
  end

  // Filter selects registered from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s2 <= (state_nxt == S_SETTLE || state_nxt == S_MEAS) && ch_nxt[1];
      s3 <= (state_nxt == S_SETTLE || state_nxt == S_MEAS) && ch_nxt[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Edge capture and counting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= colour_freq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_det  = sync2 & ~prev;
  assign meas_done = (state == S_MEAS) && (tmr == WIN_LAST);
  assign cnt_inc   = (edge_det && cnt != CNT_MAX) ? cnt + CNT_W'(1) : cnt;

  // Counter is zero outside a window and after each window's last cycle, so
  // every window starts from zero even when windows run back to back.
  always_ff @(posedge clk) begin
    if (rst || state != S_MEAS || meas_done) cnt <= '0;
    else                                     cnt <= cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= '0;
      stage_g <= '0;
      stage_b <= '0;
      stage_c <= '0;
    end else if (meas_done) begin
      case (ch)
        CH_RED:   stage_r <= cnt_inc;
        CH_BLUE:  stage_b <= cnt_inc;
        CH_CLEAR: stage_c <= cnt_inc;
        default:  stage_g <= cnt_inc;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Classification and debounce (used only in S_CLASSIFY)
  // ---------------------------------------------------------------------------
  always_comb begin
    new_r = stage_r;
    new_g = stage_g;
    new_b = stage_b;
    new_c = stage_c;
`ifdef COLSEN_AVG_EN
    if (have_prev) begin
      new_r = avg2(red_cnt,   stage_r);
      new_g = avg2(green_cnt, stage_g);
      new_b = avg2(blue_cnt,  stage_b);
      new_c = avg2(clear_cnt, stage_c);
    end
`endif

    if (32'(new_c) < 32'(CLEAR_MIN))  cls = C_NONE;
    else if (beats(new_r, new_g, new_b)) cls = C_RED;
    else if (beats(new_g, new_r, new_b)) cls = C_GREEN;
    else if (beats(new_b, new_r, new_g)) cls = C_BLUE;
    else                                 cls = C_NONE;

    if (cls == cand) streak_nxt = (streak == STRK_MAX) ? streak : streak + STRK_W'(1);
    else             streak_nxt = STRK_W'(1);

    code_nxt = (streak_nxt == STRK_MAX) ? cls : colour_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_cnt      <= '0;
      green_cnt    <= '0;
      blue_cnt     <= '0;
      clear_cnt    <= '0;
      result_valid <= 1'b0;
      colour_code  <= C_NONE;
      red_led      <= 1'b0;
      green_led    <= 1'b0;
      blue_led     <= 1'b0;
      cand         <= C_NONE;
      streak       <= '0;
    end else begin
      result_valid <= (state == S_CLASSIFY);
      if (state == S_CLASSIFY) begin
        red_cnt     <= new_r;
        green_cnt   <= new_g;
        blue_cnt    <= new_b;
        clear_cnt   <= new_c;
        cand        <= cls;
        streak      <= streak_nxt;
        colour_code <= code_nxt;
        red_led     <= (code_nxt == C_RED);
        green_led   <= (code_nxt == C_GREEN);
        blue_led    <= (code_nxt == C_BLUE);
      end
    end
  end

`ifdef COLSEN_AVG_EN
  // Averaging restarts after reset and after every pass through idle.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE)  have_prev <= 1'b0;
    else if (state == S_CLASSIFY) have_prev <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_colour_sensor_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for colour_sensor_ctrl (WINDOW=100, SETTLE=10, CLEAR_MIN=20,
// MARGIN=5, CONFIRM_ROUNDS=2). A sensor model produces exactly N pulses in any
// 100 consecutive cycles for the channel selected by s2/s3. Expected rounds
// are pushed into a queue as stimulus is issued; a monitor pops and compares
// on each result_valid. A second instance with CNT_W=4 covers saturation.
// -----------------------------------------------------------------------------
module tb_colour_sensor_ctrl;

  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, colour_freq;
  logic          s2, s3, result_valid, red_led, green_led, blue_led;
  logic [CW-1:0] red_cnt, green_cnt, blue_cnt, clear_cnt;
  logic [1:0]    colour_code;

  colour_sensor_ctrl #(
    .WINDOW_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(CW),
    .CLEAR_MIN(20), .MARGIN(5), .CONFIRM_ROUNDS(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .colour_freq(colour_freq),
    .s2(s2), .s3(s3),
    .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt), .clear_cnt(clear_cnt),
    .result_valid(result_valid), .colour_code(colour_code),
    .red_led(red_led), .green_led(green_led), .blue_led(blue_led)
  );

  // Saturation instance
  logic       rst2, enable2, freq2;
  logic       sat_s2, sat_s3, sat_rv, sat_rl, sat_gl, sat_bl;
  logic [3:0] sat_r, sat_g, sat_b, sat_c;
  logic [1:0] sat_code;

  colour_sensor_ctrl #(
    .WINDOW_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(4),
    .CLEAR_MIN(20), .MARGIN(5), .CONFIRM_ROUNDS(1)
  ) dut_sat (
    .clk(clk), .rst(rst2), .enable(enable2), .colour_freq(freq2),
    .s2(sat_s2), .s3(sat_s3),
    .red_cnt(sat_r), .green_cnt(sat_g), .blue_cnt(sat_b), .clear_cnt(sat_c),
    .result_valid(sat_rv), .colour_code(sat_code),
    .red_led(sat_rl), .green_led(sat_gl), .blue_led(sat_bl)
  );

  int checks   = 0;
  int failures = 0;
  bit sat_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sensor model: per-channel pulse rate in pulses per 100 cycles (<= 50)
  // ---------------------------------------------------------------------------
  int rate_r = 0, rate_g = 0, rate_b = 0, rate_c = 0;

  initial begin
    int acc;
    int rt;
    acc = 0;
    colour_freq = 1'b0;
    forever begin
      @(negedge clk);
      case ({s2, s3})
        2'b00:   rt = rate_r;
        2'b01:   rt = rate_b;
        2'b10:   rt = rate_c;
        default: rt = rate_g;
      endcase
      acc += rt;
      if (acc >= 100) begin
        colour_freq = 1'b1;
        acc -= 100;
      end else begin
        colour_freq = 1'b0;
      end
    end
  end

  initial begin
    freq2 = 1'b0;
    forever begin
      @(negedge clk);
      freq2 = ~freq2;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int r;
    int g;
    int b;
    int c;
    int code;
  } exp_t;

  exp_t exp_q[$];

  int m_pr = 0, m_pg = 0, m_pb = 0, m_pc = 0;
  bit m_first = 1'b1;
  int m_cand = 0, m_streak = 0, m_code = 0;

  task automatic model_reset();
    m_pr = 0; m_pg = 0; m_pb = 0; m_pc = 0;
    m_first = 1'b1;
    m_cand = 0; m_streak = 0; m_code = 0;
  endtask

  task automatic set_rates(input int r, input int g, input int b, input int c);
    rate_r = r; rate_g = g; rate_b = b; rate_c = c;
  endtask

  task automatic push_round(input int r, input int g, input int b, input int c);
    int vr, vg, vb, vc, cls;
    vr = r; vg = g; vb = b; vc = c;
`ifdef COLSEN_AVG_EN
    if (!m_first) begin
      vr = (m_pr + r) / 2;
      vg = (m_pg + g) / 2;
      vb = (m_pb + b) / 2;
      vc = (m_pc + c) / 2;
    end
`endif
    m_first = 1'b0;
    m_pr = vr; m_pg = vg; m_pb = vb; m_pc = vc;
    if (vc < 20)                           cls = 0;
    else if (vr >= vg + 5 && vr >= vb + 5) cls = 1;
    else if (vg >= vr + 5 && vg >= vb + 5) cls = 2;
    else if (vb >= vr + 5 && vb >= vg + 5) cls = 3;
    else                                   cls = 0;
    if (cls == m_cand) begin
      if (m_streak < 2) m_streak++;
    end else begin
      m_cand = cls;
      m_streak = 1;
    end
    if (m_streak == 2) m_code = cls;
    exp_q.push_back('{vr, vg, vb, vc, m_code});
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result_valid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("red_cnt",     red_cnt,     e.r);
          check("green_cnt",   green_cnt,   e.g);
          check("blue_cnt",    blue_cnt,    e.b);
          check("clear_cnt",   clear_cnt,   e.c);
          check("colour_code", colour_code, e.code);
          check("red_led",     red_led,     e.code == 1);
          check("green_led",   green_led,   e.code == 2);
          check("blue_led",    blue_led,    e.code == 3);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bounded waits
  // ---------------------------------------------------------------------------
  task automatic wait_rv(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < 2000);
    check(name, result_valid, 1);
  endtask

  task automatic wait_sel(input logic [1:0] v, input string name);
    int n;
    n = 0;
    while ({s2, s3} != v && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, {s2, s3}, v);
  endtask

  // ---------------------------------------------------------------------------
  // Saturation: 50 edges per window into 4-bit counters
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    rst2 = 1'b1;
    enable2 = 1'b0;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    enable2 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sat_rv && n < 1000);
    check("sat_rv",    sat_rv,   1);
    check("sat_red",   sat_r,    15);
    check("sat_green", sat_g,    15);
    check("sat_blue",  sat_b,    15);
    check("sat_clear", sat_c,    15);
    check("sat_code",  sat_code, 0);
    sat_done = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  int tbl[9][4] = '{
    '{30, 10, 10, 50},   // red again -> confirms red (avg build: 50 then 40)
    '{10, 50, 10,  5},   // clear too low -> none
    '{10, 50, 10,  5},   // none confirmed
    '{40, 40, 10, 50},   // red/green tie inside margin
    '{10, 50, 10, 50},   // green
    '{10, 50, 10, 50},   // green confirmed
    '{10, 10, 50, 50},   // blue
    '{10, 50, 10, 50},   // green
    '{10, 10, 50, 50}    // blue: alternation never confirms
  };

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    set_rates(0, 0, 0, 0);
    repeat (3) @(negedge clk);

    check("rst_sel",   {s2, s3},     0);
    check("rst_red",   red_cnt,      0);
    check("rst_green", green_cnt,    0);
    check("rst_blue",  blue_cnt,     0);
    check("rst_clear", clear_cnt,    0);
    check("rst_rv",    result_valid, 0);
    check("rst_code",  colour_code,  0);
    check("rst_leds",  {red_led, green_led, blue_led}, 0);

    rst = 1'b0;
    @(negedge clk);

    // Round 1 with sequence and latency checks
    set_rates(50, 10, 10, 50);
    push_round(50, 10, 10, 50);
    enable = 1'b1;
    for (int k = 0; k <= 441; k++) begin
      @(negedge clk);
      case (k)
        0, 109:   check("sel_red",   {s2, s3}, 0);
        110, 219: check("sel_blue",  {s2, s3}, 1);
        220, 329: check("sel_clear", {s2, s3}, 2);
        330, 439: check("sel_green", {s2, s3}, 3);
        440:      check("rv_before_441", result_valid, 0);
        441:      check("rv_at_441",     result_valid, 1);
        default: ;
      endcase
    end

    // Rounds 2..10
    for (int i = 0; i < 9; i++) begin
      set_rates(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3]);
      push_round(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3]);
      wait_rv("round_done");
    end

    // Reset in the middle of the green window
    set_rates(10, 50, 10, 50);
    wait_sel(2'b11, "reach_green");
    repeat (50) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_sel",   {s2, s3},     0);
    check("mid_rst_red",   red_cnt,      0);
    check("mid_rst_green", green_cnt,    0);
    check("mid_rst_blue",  blue_cnt,     0);
    check("mid_rst_clear", clear_cnt,    0);
    check("mid_rst_rv",    result_valid, 0);
    check("mid_rst_code",  colour_code,  0);
    check("mid_rst_leds",  {red_led, green_led, blue_led}, 0);
    model_reset();
    set_rates(50, 10, 10, 50);
    push_round(50, 10, 10, 50);
    rst = 1'b0;
    for (int k = 0; k <= 110; k++) begin
      @(negedge clk);
      if (k == 0 || k == 109) check("restart_red",  {s2, s3}, 0);
      if (k == 110)           check("restart_blue", {s2, s3}, 1);
    end
    wait_rv("round_after_reset");

    // enable dropped during the blue window
    set_rates(10, 10, 50, 50);
    wait_sel(2'b01, "reach_blue");
    repeat (30) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_sel",   {s2, s3},    0);
    check("dis_red",   red_cnt,     m_pr);
    check("dis_green", green_cnt,   m_pg);
    check("dis_blue",  blue_cnt,    m_pb);
    check("dis_clear", clear_cnt,   m_pc);
    check("dis_code",  colour_code, m_code);
    repeat (500) @(negedge clk);
    check("idle_sel", {s2, s3},     0);
    check("idle_rv",  result_valid, 0);

    // Restart: held red candidate confirms on the first new round
    m_first = 1'b1;
    set_rates(50, 10, 10, 50);
    push_round(50, 10, 10, 50);
    enable = 1'b1;
    wait_rv("round_after_enable");

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("sat_done", sat_done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
